// File: rtl/d5m_sensor_emulator.sv
// -----------------------------------------------------------------------------
// d5m_sensor_emulator
//
// Device-side model of the TRDB_D5M camera sensor. It generates the pixel
// clock, 12-bit pixel data, LINE_VALID, FRAME_VALID and the snapshot strobe
// with the same framing as the real sensor. The capture path can then be
// exercised without the daughter board.
//
// Build option:
//   D5M_EMU_LFSR_EN  - when defined, test pattern 3 is 12-bit LFSR noise
//                      (x^12+x^6+x^4+x+1, seeded 0xACE at reset and at every
//                      FRAME_VALID rise). When undefined, pattern 3 is the
//                      low 12 bits of the completed-frame counter.
//
// Ports:
//   ul1Clock            in   system clock
//   ul1Resetn           in   asynchronous active-low reset
//   ul1Enable           in   run enable (checked only between frames)
//   ul1SnapshotMode     in   0 = continuous, 1 = one frame per trigger
//   ul2PatternSel       in   test pattern select (latched between frames)
//   ul1SnapshotTrigger  in   asynchronous trigger, rising edge
//   ul1PixelClock       out  pixel clock = ul1Clock / 2
//   ul12PixelData       out  pixel data, 0 while LINE_VALID is low
//   ul1LineValid        out  LINE_VALID
//   ul1FrameValid       out  FRAME_VALID
//   ul1SnapshotStrobe   out  strobe ahead of exposure/readout
//   ul16FrameCount      out  completed frames, wraps at 0xFFFF
//   ul3FsmState         out  debug view of the framing FSM state
//
// Timing: every state/counter update happens on a "pixel tick", i.e. a
// ul1Clock cycle in which ul1PixelClock is 1. The outputs therefore move on
// the falling edge of the pixel clock and are stable at its rising edge.
// All video outputs are decoded from registers that share the asynchronous
// reset, so they drop to 0 as soon as reset asserts.
// -----------------------------------------------------------------------------
module d5m_sensor_emulator #(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int H_BLANK    = 160,
    parameter int FV_LEAD    = 8,
    parameter int FV_TRAIL   = 8,
    parameter int V_BLANK    = 2000,
    parameter int STROBE_LEN = 16
) (
    input  logic        ul1Clock,
    input  logic        ul1Resetn,
    input  logic        ul1Enable,
    input  logic        ul1SnapshotMode,
    input  logic [1:0]  ul2PatternSel,
    input  logic        ul1SnapshotTrigger,
    output logic        ul1PixelClock,
    output logic [11:0] ul12PixelData,
    output logic        ul1LineValid,
    output logic        ul1FrameValid,
    output logic        ul1SnapshotStrobe,
    output logic [15:0] ul16FrameCount,
    output logic [2:0]  ul3FsmState
);

    function automatic int maxInt(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // One dwell counter serves every timed state; in LINE it is the column.
    localparam int DWELL_MAX = maxInt(maxInt(maxInt(H_ACTIVE, H_BLANK),
                                             maxInt(FV_LEAD, FV_TRAIL)),
                                      maxInt(V_BLANK, STROBE_LEN));
    localparam int DW = (DWELL_MAX > 1) ? $clog2(DWELL_MAX) : 1;
    localparam int LW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;

    localparam logic [DW-1:0] H_ACTIVE_LAST   = DW'(H_ACTIVE - 1);
    localparam logic [DW-1:0] H_BLANK_LAST    = DW'(H_BLANK - 1);
    localparam logic [DW-1:0] FV_LEAD_LAST    = DW'(FV_LEAD - 1);
    localparam logic [DW-1:0] FV_TRAIL_LAST   = DW'(FV_TRAIL - 1);
    localparam logic [DW-1:0] V_BLANK_LAST    = DW'(V_BLANK - 1);
    localparam logic [DW-1:0] STROBE_LEN_LAST = DW'(STROBE_LEN - 1);
    localparam logic [LW-1:0] V_ACTIVE_LAST   = LW'(V_ACTIVE - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_STROBE   = 3'd1,
        S_FV_LEAD  = 3'd2,
        S_LINE     = 3'd3,
        S_HBLANK   = 3'd4,
        S_FV_TRAIL = 3'd5,
        S_VBLANK   = 3'd6
    } state_t;

    state_t          state;
    state_t          stateNext;
    logic [DW-1:0]   dwellCount;
    logic [DW-1:0]   dwellNext;
    logic [LW-1:0]   lineCount;
    logic [LW-1:0]   lineNext;
    logic [15:0]     frameCount;
    logic [15:0]     frameNext;
    logic [1:0]      patternReg;
    logic [1:0]      patternNext;
    logic            pixelTick;
    logic            consumeTrigger;
    logic            fvRise;

    logic [2:0]      trigSync;
    logic            trigRise;
    logic            trigPending;
    logic            trigPendingNext;

    logic [11:0]     xPix;
    logic            yBit0;
    logic            yBit3;
    logic [11:0]     pattern3Value;
    logic [11:0]     pixelValue;

    assign pixelTick = ul1PixelClock;

    // trigSync[1:0] is the synchronizer, trigSync[2] holds the previous
    // synchronized level for the rising-edge detector.
    assign trigRise = trigSync[1] & ~trigSync[2];

    // ------------------------------------------------------------------
    // State, counters, pixel clock and trigger registers
    // ------------------------------------------------------------------
    always_ff @(posedge ul1Clock or negedge ul1Resetn) begin
        if (!ul1Resetn) begin
            ul1PixelClock <= 1'b0;
            state         <= S_IDLE;
            dwellCount    <= '0;
            lineCount     <= '0;
            frameCount    <= '0;
            patternReg    <= '0;
            trigSync      <= '0;
            trigPending   <= 1'b0;
        end else begin
            ul1PixelClock <= ~ul1PixelClock;
            trigSync      <= {trigSync[1:0], ul1SnapshotTrigger};
            trigPending   <= trigPendingNext;
            if (pixelTick) begin
                state      <= stateNext;
                dwellCount <= dwellNext;
                lineCount  <= lineNext;
                frameCount <= frameNext;
                patternReg <= patternNext;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic (evaluated every cycle, committed on ticks)
    // ------------------------------------------------------------------
    always_comb begin
        stateNext      = state;
        dwellNext      = dwellCount;
        lineNext       = lineCount;
        frameNext      = frameCount;
        patternNext    = patternReg;
        consumeTrigger = 1'b0;
        fvRise         = 1'b0;

        case (state)
            S_IDLE: begin
                // Mode and pattern are only looked at here, so a change
                // during a frame lands on the next frame.
                patternNext = ul2PatternSel;
                dwellNext   = '0;
                lineNext    = '0;
                if (ul1Enable) begin
                    if (!ul1SnapshotMode) begin
                        stateNext = S_FV_LEAD;
                        fvRise    = 1'b1;
                    end else if (trigPending) begin
                        stateNext      = S_STROBE;
                        consumeTrigger = 1'b1;
                    end
                end
            end

            S_STROBE: begin
                if (dwellCount == STROBE_LEN_LAST) begin
                    dwellNext = '0;
                    stateNext = S_FV_LEAD;
                    fvRise    = 1'b1;
                end else begin
                    dwellNext = dwellCount + DW'(1);
                end
            end

            S_FV_LEAD: begin
                if (dwellCount == FV_LEAD_LAST) begin
                    dwellNext = '0;
                    stateNext = S_LINE;
                end else begin
                    dwellNext = dwellCount + DW'(1);
                end
            end

            S_LINE: begin
                if (dwellCount == H_ACTIVE_LAST) begin
                    dwellNext = '0;
                    stateNext = (lineCount == V_ACTIVE_LAST) ? S_FV_TRAIL : S_HBLANK;
                end else begin
                    dwellNext = dwellCount + DW'(1);
                end
            end

            S_HBLANK: begin
                if (dwellCount == H_BLANK_LAST) begin
                    dwellNext = '0;
                    lineNext  = lineCount + LW'(1);
                    stateNext = S_LINE;
                end else begin
                    dwellNext = dwellCount + DW'(1);
                end
            end

            S_FV_TRAIL: begin
                if (dwellCount == FV_TRAIL_LAST) begin
                    dwellNext = '0;
                    frameNext = frameCount + 16'd1;
                    stateNext = S_VBLANK;
                end else begin
                    dwellNext = dwellCount + DW'(1);
                end
            end

            S_VBLANK: begin
                if (dwellCount == V_BLANK_LAST) begin
                    dwellNext = '0;
                    stateNext = S_IDLE;
                end else begin
                    dwellNext = dwellCount + DW'(1);
                end
            end

            default: begin
                dwellNext = '0;
                stateNext = S_IDLE;
            end
        endcase
    end

    // A rise is only remembered while the FSM sits in IDLE; anything that
    // arrives during a frame is dropped rather than queued.
    always_comb begin
        trigPendingNext = trigPending;
        if (pixelTick && consumeTrigger) begin
            trigPendingNext = 1'b0;
        end else if (trigRise && (state == S_IDLE)) begin
            trigPendingNext = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Pattern 3 source
    // ------------------------------------------------------------------
`ifdef D5M_EMU_LFSR_EN
    logic [11:0] lfsr;

    // Reseeded at every FRAME_VALID rise and stepped once per active pixel,
    // so every frame carries the identical noise sequence.
    always_ff @(posedge ul1Clock or negedge ul1Resetn) begin
        if (!ul1Resetn) begin
            lfsr <= 12'hACE;
        end else if (pixelTick) begin
            if (fvRise) begin
                lfsr <= 12'hACE;
            end else if (state == S_LINE) begin
                lfsr <= {lfsr[10:0], lfsr[11] ^ lfsr[5] ^ lfsr[3] ^ lfsr[0]};
            end
        end
    end

    assign pattern3Value = lfsr;
`else
    assign pattern3Value = frameCount[11:0];
`endif

    // ------------------------------------------------------------------
    // Pixel data
    // ------------------------------------------------------------------
    assign xPix  = 12'(dwellCount);
    assign yBit0 = lineCount[0];
    assign yBit3 = |(12'(lineCount) & 12'h008);

    always_comb begin
        pixelValue = 12'h000;
        case (patternReg)
            2'd0: pixelValue = xPix;
            2'd1: begin
                if (!xPix[0] && !yBit0) begin
                    pixelValue = 12'hFFF;
                end else if (xPix[0] && yBit0) begin
                    pixelValue = 12'h000;
                end else begin
                    pixelValue = 12'h800;
                end
            end
            2'd2: pixelValue = (xPix[3] ^ yBit3) ? 12'hFFF : 12'h000;
            2'd3: pixelValue = pattern3Value;
            default: pixelValue = 12'h000;
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------
    assign ul1LineValid      = (state == S_LINE);
    assign ul1FrameValid     = (state == S_FV_LEAD) || (state == S_LINE) ||
                               (state == S_HBLANK)  || (state == S_FV_TRAIL);
    assign ul1SnapshotStrobe = (state == S_STROBE);
    assign ul12PixelData     = (state == S_LINE) ? pixelValue : 12'h000;
    assign ul16FrameCount    = frameCount;
    assign ul3FsmState       = state;

endmodule

// File: tb/tb_d5m_sensor_emulator.sv
// -----------------------------------------------------------------------------
// tb_d5m_sensor_emulator
//
// Directed bench for d5m_sensor_emulator with small framing parameters:
// H_ACTIVE=8, V_ACTIVE=4, H_BLANK=4, FV_LEAD=2, FV_TRAIL=2, V_BLANK=10,
// STROBE_LEN=3. One continuous frame is 48 FV-high ticks plus 10 VBLANK
// ticks plus one IDLE tick = 59 ticks.
//
// Outputs are sampled on the falling edge of ul1Clock right after each pixel
// tick (ul1PixelClock back at 0), i.e. once per tick.
// -----------------------------------------------------------------------------
module tb_d5m_sensor_emulator;

  localparam int H_ACTIVE   = 8;
  localparam int V_ACTIVE   = 4;
  localparam int H_BLANK    = 4;
  localparam int FV_LEAD    = 2;
  localparam int FV_TRAIL   = 2;
  localparam int V_BLANK    = 10;
  localparam int STROBE_LEN = 3;

  localparam int LINE_PITCH = H_ACTIVE + H_BLANK;                                  // 12
  localparam int FV_LEN     = FV_LEAD + V_ACTIVE * H_ACTIVE + (V_ACTIVE - 1) * H_BLANK + FV_TRAIL; // 48
  localparam int PERIOD     = FV_LEN + V_BLANK + 1;                                // 59

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic        ul1Clock = 1'b0;
  logic        ul1Resetn = 1'b0;
  logic        ul1Enable = 1'b0;
  logic        ul1SnapshotMode = 1'b0;
  logic [1:0]  ul2PatternSel = 2'd0;
  logic        ul1SnapshotTrigger = 1'b0;
  logic        ul1PixelClock;
  logic [11:0] ul12PixelData;
  logic        ul1LineValid;
  logic        ul1FrameValid;
  logic        ul1SnapshotStrobe;
  logic [15:0] ul16FrameCount;
  logic [2:0]  ul3FsmState;

  always #5 ul1Clock = ~ul1Clock;

  d5m_sensor_emulator #(
    .H_ACTIVE   (H_ACTIVE),
    .V_ACTIVE   (V_ACTIVE),
    .H_BLANK    (H_BLANK),
    .FV_LEAD    (FV_LEAD),
    .FV_TRAIL   (FV_TRAIL),
    .V_BLANK    (V_BLANK),
    .STROBE_LEN (STROBE_LEN)
  ) dut (
    .ul1Clock           (ul1Clock),
    .ul1Resetn          (ul1Resetn),
    .ul1Enable          (ul1Enable),
    .ul1SnapshotMode    (ul1SnapshotMode),
    .ul2PatternSel      (ul2PatternSel),
    .ul1SnapshotTrigger (ul1SnapshotTrigger),
    .ul1PixelClock      (ul1PixelClock),
    .ul12PixelData      (ul12PixelData),
    .ul1LineValid       (ul1LineValid),
    .ul1FrameValid      (ul1FrameValid),
    .ul1SnapshotStrobe  (ul1SnapshotStrobe),
    .ul16FrameCount     (ul16FrameCount),
    .ul3FsmState        (ul3FsmState)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int test_count = 0;
  int fail_count = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    test_count++;
    if (got !== exp) begin
      fail_count++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference helpers
  // ---------------------------------------------------------------------------
  function automatic logic [11:0] lfsr_step(input logic [11:0] l);
    logic fb;
    fb = l[11] ^ l[5] ^ l[3] ^ l[0];
    return {l[10:0], fb};
  endfunction

  function automatic logic [11:0] pix_model(input logic [1:0] pat, input int col, input int line,
                                            input logic [15:0] fc, input logic [11:0] lfsr);
    logic [11:0] v;
    v = 12'h000;
    case (pat)
      2'd0: v = 12'(col);
      2'd1: begin
        if ((col % 2 == 0) && (line % 2 == 0)) v = 12'hFFF;
        else if ((col % 2 == 1) && (line % 2 == 1)) v = 12'h000;
        else v = 12'h800;
      end
      2'd2: v = ((((col >> 3) & 1) ^ ((line >> 3) & 1)) != 0) ? 12'hFFF : 12'h000;
      default: begin
`ifdef D5M_EMU_LFSR_EN
        v = lfsr;
`else
        v = fc[11:0];
`endif
      end
    endcase
    return v;
  endfunction

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  // Advance to the sample point right after the next pixel tick.
  task automatic next_tick();
    int guard;
    guard = 0;
    do begin
      @(negedge ul1Clock);
      guard++;
    end while (ul1PixelClock !== 1'b0 && guard < 4);
    if (guard >= 4) check_eq("pixel_clock_toggle", 32'(ul1PixelClock), 32'd0);
  endtask

  // Hold reset for a few clocks, then release on a falling edge.
  task automatic do_reset(input logic en, input logic mode, input logic [1:0] pat);
    ul1Resetn          = 1'b0;
    ul1Enable          = en;
    ul1SnapshotMode    = mode;
    ul2PatternSel      = pat;
    ul1SnapshotTrigger = 1'b0;
    repeat (3) @(negedge ul1Clock);
    ul1Resetn = 1'b1;
  endtask

  // Continuous-mode run from reset release, checked tick by tick against the
  // frame timeline. After sample switch_at the pattern input changes to
  // new_pat; it takes effect from the first frame whose IDLE tick follows.
  task automatic run_check(input int n_ticks, input int switch_at, input logic [1:0] new_pat);
    logic [1:0]  old_pat;
    logic [1:0]  pat;
    logic [15:0] exp_fc;
    logic [11:0] lfsr;
    logic [11:0] exp_data;
    logic        exp_fv;
    logic        exp_lv;
    int          f, p, q, col, line;
    old_pat = ul2PatternSel;
    exp_fc  = 16'd0;
    lfsr    = 12'hACE;
    for (int k = 0; k < n_ticks; k++) begin
      next_tick();
      f   = k / PERIOD;
      p   = k % PERIOD;
      pat = (PERIOD * f > switch_at) ? new_pat : old_pat;
      if (p == 0) lfsr = 12'hACE;
      if (p == FV_LEN) exp_fc = exp_fc + 16'd1;
      exp_fv   = (p < FV_LEN);
      exp_lv   = 1'b0;
      exp_data = 12'h000;
      q = p - FV_LEAD;
      if (q >= 0 && q < V_ACTIVE * LINE_PITCH - H_BLANK && (q % LINE_PITCH) < H_ACTIVE) begin
        line     = q / LINE_PITCH;
        col      = q % LINE_PITCH;
        exp_lv   = 1'b1;
        exp_data = pix_model(pat, col, line, exp_fc, lfsr);
        lfsr     = lfsr_step(lfsr);
      end
      check_eq($sformatf("fv@%0d", k), 32'(ul1FrameValid), 32'(exp_fv));
      check_eq($sformatf("lv@%0d", k), 32'(ul1LineValid), 32'(exp_lv));
      check_eq($sformatf("data@%0d", k), 32'(ul12PixelData), 32'(exp_data));
      check_eq($sformatf("frame_count@%0d", k), 32'(ul16FrameCount), 32'(exp_fc));
      check_eq($sformatf("strobe@%0d", k), 32'(ul1SnapshotStrobe), 32'd0);
      if (k == switch_at) ul2PatternSel = new_pat;
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_pclk"},   32'(ul1PixelClock),     32'd0);
    check_eq({tag, "_data"},   32'(ul12PixelData),     32'd0);
    check_eq({tag, "_lv"},     32'(ul1LineValid),      32'd0);
    check_eq({tag, "_fv"},     32'(ul1FrameValid),     32'd0);
    check_eq({tag, "_strobe"}, 32'(ul1SnapshotStrobe), 32'd0);
    check_eq({tag, "_fc"},     32'(ul16FrameCount),    32'd0);
    check_eq({tag, "_state"},  32'(ul3FsmState),       32'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int fv_cnt, lv_cnt, lv_rises, fv_rises, strobe_cnt;
    int first_fv, first_strobe, last_strobe;
    logic prev_fv, prev_lv;

    // Reset state with the clock running.
    ul1Resetn = 1'b0;
    ul1Enable = 1'b1;
    repeat (4) @(negedge ul1Clock);
    check_outputs_zero("reset");

    // Continuous, pattern 0: ramp 0..7 per line, 48-tick FV, 59-tick period.
    do_reset(1'b1, 1'b0, 2'd0);
    run_check(2 * PERIOD + 12, 100000, 2'd0);

    // Pattern 1 on frame 0; pattern 3 selected mid-frame lands on frame 1.
    do_reset(1'b1, 1'b0, 2'd1);
    run_check(2 * PERIOD + 2, 20, 2'd3);

    // Pattern 2 on frame 0, then pattern 1 on frames 1 and 2.
    do_reset(1'b1, 1'b0, 2'd2);
    run_check(3 * PERIOD, 30, 2'd1);

    // Reset in the middle of LINE (frame 1, column 4).
    do_reset(1'b1, 1'b0, 2'd0);
    run_check(PERIOD + 7, 100000, 2'd0);
    check_eq("pre_reset_lv", 32'(ul1LineValid), 32'd1);
    #2;
    ul1Resetn = 1'b0;
    #1;
    check_outputs_zero("async_reset");
    repeat (3) @(negedge ul1Clock);
    ul1Resetn = 1'b1;
    run_check(PERIOD + 1, 100000, 2'd0);

    // Enable dropped during line 2: frame completes, then FV stays low.
    do_reset(1'b1, 1'b0, 2'd0);
    fv_cnt = 0; lv_cnt = 0; lv_rises = 0; prev_lv = 1'b0;
    for (int k = 0; k < 150; k++) begin
      next_tick();
      if (ul1FrameValid) fv_cnt++;
      if (ul1LineValid) begin
        lv_cnt++;
        if (!prev_lv) lv_rises++;
      end
      prev_lv = ul1LineValid;
      if (k == 28) ul1Enable = 1'b0;
    end
    check_eq("en_drop_fv_ticks", 32'(fv_cnt), 32'(FV_LEN));
    check_eq("en_drop_lv_pulses", 32'(lv_rises), 32'(V_ACTIVE));
    check_eq("en_drop_lv_ticks", 32'(lv_cnt), 32'(V_ACTIVE * H_ACTIVE));
    check_eq("en_drop_frame_count", 32'(ul16FrameCount), 32'd1);
    check_eq("en_drop_state_idle", 32'(ul3FsmState), 32'd0);

    // Snapshot: one trigger gives strobe + exactly one frame; a second
    // trigger during LINE is ignored.
    do_reset(1'b1, 1'b1, 2'd0);
    fv_cnt = 0; fv_rises = 0; strobe_cnt = 0;
    first_fv = -1; first_strobe = -1; last_strobe = -1; prev_fv = 1'b0;
    for (int k = 0; k < 170; k++) begin
      next_tick();
      if (k == 14) check_eq("snap_no_trigger_fv", 32'(ul1FrameValid), 32'd0);
      if (ul1SnapshotStrobe) begin
        strobe_cnt++;
        if (first_strobe < 0) first_strobe = k;
        last_strobe = k;
      end
      if (ul1FrameValid) begin
        fv_cnt++;
        if (!prev_fv) begin
          fv_rises++;
          if (first_fv < 0) first_fv = k;
        end
      end
      prev_fv = ul1FrameValid;
      if (k == 15) ul1SnapshotTrigger = 1'b1;
      if (k == 17) ul1SnapshotTrigger = 1'b0;
      if (first_fv >= 0 && k == first_fv + 5) begin
        check_eq("snap_second_trig_in_line", 32'(ul1LineValid), 32'd1);
        ul1SnapshotTrigger = 1'b1;
      end
      if (first_fv >= 0 && k == first_fv + 7) ul1SnapshotTrigger = 1'b0;
    end
    check_eq("snap_strobe_ticks", 32'(strobe_cnt), 32'(STROBE_LEN));
    check_eq("snap_strobe_contiguous", 32'(last_strobe - first_strobe + 1), 32'(STROBE_LEN));
    check_eq("snap_fv_after_strobe", 32'(first_fv), 32'(last_strobe + 1));
    check_eq("snap_fv_rises", 32'(fv_rises), 32'd1);
    check_eq("snap_fv_ticks", 32'(fv_cnt), 32'(FV_LEN));
    check_eq("snap_frame_count", 32'(ul16FrameCount), 32'd1);
    check_eq("snap_fv_final", 32'(ul1FrameValid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule

// File: doc/d5m_sensor_emulator.md
Name: d5m_sensor_emulator

Overview:
- Synthesizable device-side model of the TRDB_D5M camera. It drives the pixel clock, 12-bit pixel data, LINE_VALID, FRAME_VALID and snapshot strobe exactly as the sensor would.
- Used to exercise the capture/driver path (on-chip loopback or bench) without the daughter board.
- Continuous mode or snapshot mode. Four selectable test patterns. The I2C lines (Sda/Scl) are not part of this block.

Parameters:
- H_ACTIVE, 640, active pixels per line
- V_ACTIVE, 480, active lines per frame
- H_BLANK, 160, pixel ticks with LV low between lines
- FV_LEAD, 8, pixel ticks from FV rise to first LV rise
- FV_TRAIL, 8, pixel ticks from last LV fall to FV fall
- V_BLANK, 2000, pixel ticks with FV low between frames
- STROBE_LEN, 16, pixel ticks of strobe before FV rise (snapshot mode)

Ports:
- ul1Clock  in  1  system clock
- ul1Resetn  in  1  asynchronous active-low reset
- ul1Enable  in  1  run enable
- ul1SnapshotMode  in  1  0 = continuous, 1 = one frame per trigger
- ul2PatternSel  in  2  test pattern select
- ul1SnapshotTrigger  in  1  asynchronous trigger, rising edge
- ul1PixelClock  out  1  pixel clock = ul1Clock/2
- ul12PixelData  out  12  pixel data
- ul1LineValid  out  1  LINE_VALID
- ul1FrameValid  out  1  FRAME_VALID
- ul1SnapshotStrobe  out  1  strobe before exposure/readout
- ul16FrameCount  out  16  completed frames, wraps at 0xFFFF

Behaviour:
Reset:
- All outputs 0.
- FSM in IDLE; all counters 0; trigger synchronizer cleared.
- Reset mid-frame aborts immediately. There is no partial-frame completion.

Pixel clock and tick:
- ul1PixelClock is a toggle register, 0 after reset, toggling every ul1Clock cycle.
- Pixel tick = a ul1Clock cycle in which ul1PixelClock is 1.
- All FSM, counter and output-data updates occur only on ticks. Outputs therefore change on the falling edge of the pixel clock and are stable across the rising edge.
- All durations below are in ticks.

Trigger path:
- ul1SnapshotTrigger passes through a 2-flop synchronizer plus an edge detector.
- A detected rise is latched as pending until consumed on a tick.
- Pending is consumed only in IDLE. Triggers arriving outside IDLE are dropped.

FSM states:
- IDLE:
  - Continuous mode, ul1Enable=1: go to FV_LEAD.
  - Snapshot mode, ul1Enable=1, trigger pending: go to STROBE.
- STROBE: strobe=1 for STROBE_LEN ticks, then strobe=0 and go to FV_LEAD.
- FV_LEAD: FV=1, LV=0 for FV_LEAD ticks, then LINE.
- LINE: FV=1, LV=1 for H_ACTIVE ticks; data valid each tick.
  - Not the last line: go to HBLANK.
  - Last line (line count = V_ACTIVE-1): go to FV_TRAIL.
- HBLANK: LV=0 for H_BLANK ticks, line count +1, then LINE.
- FV_TRAIL: FV=1, LV=0 for FV_TRAIL ticks. Then FV=0, ul16FrameCount +1, go to VBLANK.
- VBLANK: FV=0 for V_BLANK ticks, then IDLE.
  - In continuous mode with ul1Enable=1, IDLE lasts exactly one tick.

Mode and enable rules:
- ul1Enable deasserted mid-frame: the current frame completes through VBLANK, then the FSM holds in IDLE.
- ul1SnapshotMode and ul2PatternSel are sampled only in IDLE. Changes during a frame take effect at the next frame.

Data:
- ul12PixelData = 0 whenever LV=0.
- Column count x runs 0..H_ACTIVE-1; line count y runs 0..V_ACTIVE-1.
- Patterns:
  - 0 = ramp: x[11:0].
  - 1 = Bayer bars: even line/even col 0xFFF, odd/odd 0x000, others 0x800.
  - 2 = checkerboard: (x[3]^y[3]) ? 0xFFF : 0x000.
  - 3 = frame id: ul16FrameCount[11:0].
- Counter widths are sized with $clog2 of the parameters. Counters never wrap within a frame.

Optional Feature:
- Macro: D5M_EMU_LFSR_EN.
- Defined: pattern 3 becomes 12-bit Fibonacci LFSR noise.
  - Polynomial x^12+x^6+x^4+x+1, seed 0xACE at reset and at each FV rise.
  - Advances once per active pixel, so every frame is identical.
- Undefined: pattern 3 = frame id; no LFSR logic is generated.

Test Plan:
- H_ACTIVE=8, V_ACTIVE=4, H_BLANK=4, FV_LEAD=2, FV_TRAIL=2, V_BLANK=10, continuous, pattern 0 -> per frame: 4 LV pulses of 8 ticks, data 0..7 each line, FV high for 2+4*8+3*4+2 = 48 ticks, FV period 49+10 = 59 ticks (includes the 1-tick IDLE), ul16FrameCount increments once per frame.
- Snapshot mode, STROBE_LEN=3, single trigger pulse -> strobe high 3 ticks, exactly one frame, FV stays 0 after it; a second trigger pulse during LINE is ignored.
- Enable dropped during line 2 -> frame completes with 4 lines, then FV stays 0 indefinitely.
- Reset asserted during LINE -> all outputs 0 in the same cycle, without waiting for a clock; after release, the first frame is preceded by FV_LEAD and starts at x=0, y=0.
- Pattern 1, frames 0 and 1 -> line 0 = FFF,800,FFF,800...; line 1 = 800,000,800,000...; pattern 3 (macro off) on frame 1 -> all active pixels 0x001.
- Pattern 3 with D5M_EMU_LFSR_EN -> first pixel 0xACE, sequence identical across two consecutive frames.
